sc_scratchpad: RTL and testbench
================================

Name: sc_scratchpad

Overview:
Register file (scratchpad) for the microcoded datapath, directly downstream of the external register-address muxes. It consumes three 6-bit register addresses (A, B read; C write), each already selected from either the MIR field or the zero-extended 5-bit instruction-register field. It drives the A and B buses into the ALU and captures the C bus on write. It holds 32 user registers (%r0..%r31) plus 6 microcode temporaries (%r32..%r37).

Parameters:
DATAWIDTH_BUS, 32, width of the A/B/C data buses and of each register
DATAWIDTH_MIR_DIRECTION, 6, width of every register address
NUMBER_REGISTERS, 38, implemented registers (addresses 0..NUMBER_REGISTERS-1)

Ports:
SC_SCRATCHPAD_CLOCK_50  input  1  system clock; all state updates on rising edge
SC_SCRATCHPAD_ResetInLow_In  input  1  asynchronous active-low reset
SC_SCRATCHPAD_Write_In  input  1  write enable for port C (high = write)
SC_SCRATCHPAD_AAddress_InBus  input  6  read address, port A
SC_SCRATCHPAD_BAddress_InBus  input  6  read address, port B
SC_SCRATCHPAD_CAddress_InBus  input  6  write address, port C
SC_SCRATCHPAD_CData_InBus  input  DATAWIDTH_BUS  write data from C bus
SC_SCRATCHPAD_DebugAddress_InBus  input  6  read address, board debug port
SC_SCRATCHPAD_AData_OutBus  output  DATAWIDTH_BUS  contents at A address
SC_SCRATCHPAD_BData_OutBus  output  DATAWIDTH_BUS  contents at B address
SC_SCRATCHPAD_DebugData_OutBus  output  DATAWIDTH_BUS  contents at debug address
SC_SCRATCHPAD_WriteCount_OutBus  output  8  count of committed writes, wraps

Behaviour:
- Reset: one clock, SC_SCRATCHPAD_CLOCK_50; asynchronous active-low reset, SC_SCRATCHPAD_ResetInLow_In. Reset is asynchronous assert; deassertion takes effect at the next rising edge.
- While reset is low: all 38 registers = 0 and WriteCount = 0. All read outputs therefore read 0.
- Reset asserted mid-write: the reset wins; that write is lost.
- Storage: registers 1..37 are flops. %r0 is not stored.
- Reads:
  - Ports A, B and Debug are combinational (asynchronous) reads.
  - Address 0 always reads 0.
  - Addresses 38..63 read 0.
- Write commit: at a rising edge where Write_In = 1, CAddress in 1..37 and reset is high, register[CAddress] <= CData.
- Ignored writes:
  - CAddress = 0 or 38..63: write discarded silently.
  - Write_In = 0: no write; all registers hold.
- Write latency (base build): the new value appears on the A/B/Debug outputs after the edge, i.e. one cycle later. Same-cycle reads of the address being written return the old value.
- WriteCount:
  - Increments by 1 only on committed writes, not on discarded ones.
  - 8-bit, wraps 255 -> 0.
  - Registered output.
- Same address on A, B and Debug: all return identical data; no priority issue.
- Simultaneous read and write of the same register: same-cycle behaviour is defined by the optional feature below.
- No X propagation: every output is driven in every state.

Optional Feature:
Macro SC_SCRATCHPAD_BYPASS_EN.
- Defined: write-through forwarding. In the cycle where Write_In = 1 and CAddress is in 1..37 and equals the A or B address, that output returns CData_InBus combinationally instead of the stored value.
  - The Debug port is never bypassed.
  - Addresses 0 and 38..63 are never bypassed.
- Undefined: no forwarding; behaviour exactly as in Behaviour (old value until after the edge).
- Register contents and WriteCount are identical in both builds.

Test Plan:
- Reset low mid-run after writing %r5=0x1234 -> A, B, Debug = 0 for addresses 5 and 37 immediately (asynchronous); WriteCount = 0.
- Write 0xDEADBEEF to C=10, then read A=10, B=10 next cycle -> both 0xDEADBEEF; WriteCount = 1.
- Write 0xFFFFFFFF to C=0, then write to C=45 -> A=0 reads 0; B=45 reads 0; WriteCount unchanged.
- Same-cycle write C=3, data 0x55 (old value 0x11), A=3:
  - Without BYPASS: A = 0x11 before the edge, 0x55 after.
  - With BYPASS: A = 0x55 in the same cycle.
  - Debug=3 shows 0x11 before the edge in both builds.
- 256 committed writes to C=37 -> WriteCount wraps to 0; %r37 holds the last data value.
- Write_In = 0 with C=7, data 0xAA for 4 cycles -> %r7 unchanged; WriteCount unchanged.

Source files
------------

// File: rtl/sc_scratchpad.sv
// Scratchpad register file: 37 stored registers (%r1..%r37), %r0 and 38..63 read as zero.
// Optional write-through forwarding onto the A/B ports when SC_SCRATCHPAD_BYPASS_EN is defined.
module sc_scratchpad #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int NUMBER_REGISTERS        = 38
) (
    input  logic                               SC_SCRATCHPAD_CLOCK_50,
    input  logic                               SC_SCRATCHPAD_ResetInLow_In,
    input  logic                               SC_SCRATCHPAD_Write_In,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_SCRATCHPAD_AAddress_InBus,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_SCRATCHPAD_BAddress_InBus,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_SCRATCHPAD_CAddress_InBus,
    input  logic [DATAWIDTH_BUS-1:0]           SC_SCRATCHPAD_CData_InBus,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_SCRATCHPAD_DebugAddress_InBus,
    output logic [DATAWIDTH_BUS-1:0]           SC_SCRATCHPAD_AData_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           SC_SCRATCHPAD_BData_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           SC_SCRATCHPAD_DebugData_OutBus,
    output logic [7:0]                         SC_SCRATCHPAD_WriteCount_OutBus
);

    localparam int AW = DATAWIDTH_MIR_DIRECTION;
    localparam int DW = DATAWIDTH_BUS;

    logic [DW-1:0] regs [1:NUMBER_REGISTERS-1];
    logic [7:0]    write_count;
    logic          write_hit;
    logic [DW-1:0] a_stored;
    logic [DW-1:0] b_stored;
    logic [DW-1:0] dbg_stored;

    // Only in-range, non-zero targets commit; everything else is silently dropped.
    assign write_hit = SC_SCRATCHPAD_Write_In
                     && (SC_SCRATCHPAD_CAddress_InBus != '0)
                     && (SC_SCRATCHPAD_CAddress_InBus < AW'(NUMBER_REGISTERS));

    always_ff @(posedge SC_SCRATCHPAD_CLOCK_50 or negedge SC_SCRATCHPAD_ResetInLow_In) begin
        if (!SC_SCRATCHPAD_ResetInLow_In) begin
            for (int i = 1; i < NUMBER_REGISTERS; i++) regs[i] <= '0;
            write_count <= '0;
        end else if (write_hit) begin
            for (int i = 1; i < NUMBER_REGISTERS; i++)
                if (SC_SCRATCHPAD_CAddress_InBus == AW'(i)) regs[i] <= SC_SCRATCHPAD_CData_InBus;
            write_count <= write_count + 8'd1;
        end
    end

    // Read muxes: addresses with no matching register fall through to zero.
    always_comb begin
        a_stored   = '0;
        b_stored   = '0;
        dbg_stored = '0;
        for (int i = 1; i < NUMBER_REGISTERS; i++) begin
            if (SC_SCRATCHPAD_AAddress_InBus == AW'(i))     a_stored   = regs[i];
            if (SC_SCRATCHPAD_BAddress_InBus == AW'(i))     b_stored   = regs[i];
            if (SC_SCRATCHPAD_DebugAddress_InBus == AW'(i)) dbg_stored = regs[i];
        end
    end

`ifdef SC_SCRATCHPAD_BYPASS_EN
    assign SC_SCRATCHPAD_AData_OutBus =
        (write_hit && SC_SCRATCHPAD_CAddress_InBus == SC_SCRATCHPAD_AAddress_InBus)
        ? SC_SCRATCHPAD_CData_InBus : a_stored;
    assign SC_SCRATCHPAD_BData_OutBus =
        (write_hit && SC_SCRATCHPAD_CAddress_InBus == SC_SCRATCHPAD_BAddress_InBus)
        ? SC_SCRATCHPAD_CData_InBus : b_stored;
`else
    assign SC_SCRATCHPAD_AData_OutBus = a_stored;
    assign SC_SCRATCHPAD_BData_OutBus = b_stored;
`endif

    assign SC_SCRATCHPAD_DebugData_OutBus  = dbg_stored;
    assign SC_SCRATCHPAD_WriteCount_OutBus = write_count;

endmodule

// File: tb/tb_sc_scratchpad.sv
// Directed bench for sc_scratchpad: reset, commit/discard rules, same-cycle reads, counter wrap.
module tb_sc_scratchpad;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [5:0]  a_addr, b_addr, c_addr, d_addr;
    logic [31:0] c_data;
    logic [31:0] a_data, b_data, d_data;
    logic [7:0]  wcount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sc_scratchpad dut (
        .SC_SCRATCHPAD_CLOCK_50          (clk),
        .SC_SCRATCHPAD_ResetInLow_In     (rst_n),
        .SC_SCRATCHPAD_Write_In          (we),
        .SC_SCRATCHPAD_AAddress_InBus    (a_addr),
        .SC_SCRATCHPAD_BAddress_InBus    (b_addr),
        .SC_SCRATCHPAD_CAddress_InBus    (c_addr),
        .SC_SCRATCHPAD_CData_InBus       (c_data),
        .SC_SCRATCHPAD_DebugAddress_InBus(d_addr),
        .SC_SCRATCHPAD_AData_OutBus      (a_data),
        .SC_SCRATCHPAD_BData_OutBus      (b_data),
        .SC_SCRATCHPAD_DebugData_OutBus  (d_data),
        .SC_SCRATCHPAD_WriteCount_OutBus (wcount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [5:0] addr, input logic [31:0] data);
        we = 1'b1; c_addr = addr; c_data = data;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0;
        a_addr = '0; b_addr = '0; c_addr = '0; d_addr = '0; c_data = '0;
        #2;
        check("rst_a",     a_data, 32'h0);
        check("rst_count", {24'h0, wcount}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic commit and read-back on both ports
        write(6'd10, 32'hDEADBEEF);
        a_addr = 6'd10; b_addr = 6'd10; d_addr = 6'd10;
        #1;
        check("r10_a",     a_data, 32'hDEADBEEF);
        check("r10_b",     b_data, 32'hDEADBEEF);
        check("r10_dbg",   d_data, 32'hDEADBEEF);
        check("r10_count", {24'h0, wcount}, 32'h1);

        // Discarded writes to %r0 and out-of-range address
        write(6'd0,  32'hFFFFFFFF);
        write(6'd45, 32'hFFFFFFFF);
        a_addr = 6'd0; b_addr = 6'd45;
        #1;
        check("r0_reads0",   a_data, 32'h0);
        check("r45_reads0",  b_data, 32'h0);
        check("discard_cnt", {24'h0, wcount}, 32'h1);

        // Same-cycle write/read of %r3
        write(6'd3, 32'h11);
        a_addr = 6'd3; d_addr = 6'd3;
        we = 1'b1; c_addr = 6'd3; c_data = 32'h55;
        #1;
`ifdef SC_SCRATCHPAD_BYPASS_EN
        check("r3_same_a",   a_data, 32'h55);
`else
        check("r3_same_a",   a_data, 32'h11);
`endif
        check("r3_same_dbg", d_data, 32'h11);
        tick();
        we = 1'b0;
        #1;
        check("r3_after_a",   a_data, 32'h55);
        check("r3_after_dbg", d_data, 32'h55);
        check("r3_count",     {24'h0, wcount}, 32'h3);

        // Write_In low holds %r7
        write(6'd7, 32'h77);
        we = 1'b0; c_addr = 6'd7; c_data = 32'hAA;
        repeat (4) tick();
        d_addr = 6'd7;
        #1;
        check("r7_hold",     d_data, 32'h77);
        check("r7_hold_cnt", {24'h0, wcount}, 32'h4);

        // Asynchronous reset mid-run, with a write pending at the edge
        write(6'd5, 32'h1234);
        a_addr = 6'd5; b_addr = 6'd37; d_addr = 6'd5;
        #1;
        check("r5_pre_rst", a_data, 32'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_a",   a_data, 32'h0);
        check("rst_mid_b",   b_data, 32'h0);
        check("rst_mid_dbg", d_data, 32'h0);
        check("rst_mid_cnt", {24'h0, wcount}, 32'h0);
        we = 1'b1; c_addr = 6'd5; c_data = 32'h9999;
        tick();
        we = 1'b0;
        check("rst_wins", a_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // 256 committed writes wrap the counter
        for (int i = 0; i < 256; i++) begin
            write(6'd37, 32'h1000 + i);
            if (i == 254) check("cnt_255", {24'h0, wcount}, 32'hFF);
        end
        d_addr = 6'd37;
        #1;
        check("cnt_wrap", {24'h0, wcount}, 32'h0);
        check("r37_last", d_data, 32'h10FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
